// File: rtl/tdm_slot_scheduler_pkg.sv
// tdm_pkg: shared types and helpers for the TDM slot scheduler.
// Optional feature macro: TDM_SCHED_MUTE_ON_UNDERRUN_EN.
package tdm_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  localparam int unsigned SLOTS_PER_SRC = 2;
  localparam int unsigned LEFT_OFS      = 0;
  localparam int unsigned RIGHT_OFS     = 1;

  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_scheduler_if.sv
// Source-side handshake and frame outputs of the scheduler.
// Optional feature macro: TDM_SCHED_MUTE_ON_UNDERRUN_EN.
interface tdm_slot_scheduler_if #(
  parameter int G_BITS    = 16,
  parameter int G_SOURCES = 4
);

  logic [G_SOURCES-1:0]          in_slot_enable;
  logic [G_SOURCES-1:0]          in_valid;
  logic [G_SOURCES*G_BITS-1:0]   in_left;
  logic [G_SOURCES*G_BITS-1:0]   in_right;
  logic [G_SOURCES-1:0]          out_ready;
  logic [2*G_SOURCES*G_BITS-1:0] out_slots;
  logic                          out_frame_strobe;
  logic [G_SOURCES-1:0]          out_underrun;
  logic                          out_running;

  modport master (
    output in_slot_enable,
    output in_valid,
    output in_left,
    output in_right,
    input  out_ready,
    input  out_slots,
    input  out_frame_strobe,
    input  out_underrun,
    input  out_running
  );

  modport slave (
    input  in_slot_enable,
    input  in_valid,
    input  in_left,
    input  in_right,
    output out_ready,
    output out_slots,
    output out_frame_strobe,
    output out_underrun,
    output out_running
  );

endinterface

// File: rtl/tdm_slot_scheduler_buffer.sv
// tdm_sample_buffer: one-entry stereo buffer with last-value hold.
// Optional feature macro: TDM_SCHED_MUTE_ON_UNDERRUN_EN.
module tdm_sample_buffer
  import tdm_pkg::*;
#(
  parameter int G_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              valid,
  input  logic              xfer,
  input  logic [G_BITS-1:0] left,
  input  logic [G_BITS-1:0] right,
  output logic              ready,
  output logic              full,
  output logic              underrun,
  output logic [G_BITS-1:0] slot_left,
  output logic [G_BITS-1:0] slot_right
);

  logic [G_BITS-1:0] buf_left;
  logic [G_BITS-1:0] buf_right;
  logic              accept;
  logic              deliver;

`ifndef TDM_SCHED_MUTE_ON_UNDERRUN_EN
  logic [G_BITS-1:0] last_left;
  logic [G_BITS-1:0] last_right;
`endif

  // Disabled sources always look ready so they drain and discard.
  assign ready    = ~full | ~enable;
  assign accept   = valid & ready & enable;
  assign deliver  = xfer & enable & full;
  assign underrun = enable & ~full;

  // Slot content offered for the transfer cycle.
  always_comb begin
    slot_left  = '0;
    slot_right = '0;
    if (enable && full) begin
      slot_left  = buf_left;
      slot_right = buf_right;
    end else if (enable) begin
`ifdef TDM_SCHED_MUTE_ON_UNDERRUN_EN
      slot_left  = '0;
      slot_right = '0;
`else
      slot_left  = last_left;
      slot_right = last_right;
`endif
    end
  end

  // Fill on accept, drain on delivery; accept needs an empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 1'b0;
      buf_left  <= '0;
      buf_right <= '0;
    end else if (accept) begin
      full      <= 1'b1;
      buf_left  <= left;
      buf_right <= right;
    end else if (deliver) begin
      full      <= 1'b0;
    end
  end

`ifndef TDM_SCHED_MUTE_ON_UNDERRUN_EN
  // Remember the last delivered pair for underrun repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_left  <= '0;
      last_right <= '0;
    end else if (deliver) begin
      last_left  <= buf_left;
      last_right <= buf_right;
    end
  end
`endif

endmodule

// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler: packs stereo sources into a strobed TDM frame.
// Optional feature macro: TDM_SCHED_MUTE_ON_UNDERRUN_EN.
module tdm_slot_scheduler
  import tdm_pkg::*;
#(
  parameter int G_BITS        = 16,
  parameter int G_SOURCES     = 4,
  parameter int G_FRAME_MCLKS = 512
) (
  input logic                 in_mclk,
  input logic                 in_reset,
  tdm_slot_scheduler_if.slave bus
);

  localparam int CW = cnt_width(G_FRAME_MCLKS);
  localparam int SW = 2 * G_SOURCES * G_BITS;
  localparam logic [CW-1:0] LAST = CW'(G_FRAME_MCLKS - 1);

  sched_state_t state;
  sched_state_t state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  logic                 any_en;
  logic                 primed;
  logic                 xfer;
  logic [G_SOURCES-1:0] ready;
  logic [G_SOURCES-1:0] full;
  logic [G_SOURCES-1:0] urun;
  logic [SW-1:0]        slots_next;

  logic [SW-1:0]        slots_q;
  logic                 strobe_q;
  logic [G_SOURCES-1:0] urun_q;

  for (genvar i = 0; i < G_SOURCES; i++) begin : g_src
    localparam int LO =
      (int'(SLOTS_PER_SRC) * i + int'(LEFT_OFS)) * G_BITS;
    localparam int RO =
      (int'(SLOTS_PER_SRC) * i + int'(RIGHT_OFS)) * G_BITS;

    tdm_sample_buffer #(
      .G_BITS (G_BITS)
    ) u_buf (
      .clk        (in_mclk),
      .rst        (in_reset),
      .enable     (bus.in_slot_enable[i]),
      .valid      (bus.in_valid[i]),
      .xfer       (xfer),
      .left       (bus.in_left[i*G_BITS +: G_BITS]),
      .right      (bus.in_right[i*G_BITS +: G_BITS]),
      .ready      (ready[i]),
      .full       (full[i]),
      .underrun   (urun[i]),
      .slot_left  (slots_next[LO +: G_BITS]),
      .slot_right (slots_next[RO +: G_BITS])
    );
  end

  assign any_en = |bus.in_slot_enable;
  assign primed = any_en & (&(full | ~bus.in_slot_enable));
  assign xfer   = (state == RUN) & any_en & (cnt == LAST);

  // Next-state and frame counter; counter parked at 0 in SYNC.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      SYNC: begin
        cnt_next = '0;
        if (primed) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!any_en) begin
          state_next = SYNC;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = SYNC;
        cnt_next   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge in_mclk) begin
    if (in_reset) begin
      state <= SYNC;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Frame image, strobe and underrun flags move together.
  always_ff @(posedge in_mclk) begin
    if (in_reset) begin
      slots_q  <= '0;
      strobe_q <= 1'b0;
      urun_q   <= '0;
    end else begin
      strobe_q <= xfer;
      urun_q   <= xfer ? urun : '0;
      if (xfer) begin
        slots_q <= slots_next;
      end
    end
  end

  assign bus.out_ready        = ready;
  assign bus.out_slots        = slots_q;
  assign bus.out_frame_strobe = strobe_q;
  assign bus.out_underrun     = urun_q;
  assign bus.out_running      = (state == RUN);

endmodule

// File: doc/tdm_slot_scheduler.md
# tdm_slot_scheduler

Collects stereo sample pairs from up to G_SOURCES I2S receivers through per-source valid/ready handshakes. Packs them into one TDM frame image and issues a single-cycle frame strobe at a fixed MCLK-derived frame rate. Sits between the I2S receive front ends and the TDM transmitter, and drives that transmitter's frame data and frame-strobe inputs. Handles start-up alignment, missing samples (underrun) and per-source slot enabling.

## Interface
- G_BITS, 16, bits per sample (one slot)
- G_SOURCES, 4, number of stereo sources; source i occupies slots 2i (left) and 2i+1 (right)
- G_FRAME_MCLKS, 512, MCLK cycles per TDM frame; legal range 4 to 65535
- in_mclk  input  1  sole clock; all logic on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_slot_enable  input  G_SOURCES  per-source enable
- in_valid  input  G_SOURCES  source i offers a sample pair
- in_left  input  G_SOURCES*G_BITS  left samples, source i at bits [i*G_BITS +: G_BITS]
- in_right  input  G_SOURCES*G_BITS  right samples, same packing
- out_ready  output  G_SOURCES  source i buffer can accept a pair
- out_slots  output  2*G_SOURCES*G_BITS  frame image; slot k at [k*G_BITS +: G_BITS]
- out_frame_strobe  output  1  one-cycle pulse: out_slots is new this cycle
- out_underrun  output  G_SOURCES  per source; valid on the strobe cycle
- out_running  output  1  scheduler in RUN state

## Operation
- Per source: one-entry buffer (left, right, full flag). out_ready[i] = ~full[i] | ~in_slot_enable[i].
- Accept: a sample pair is accepted when in_valid[i] & out_ready[i] are both high. Disabled sources accept and discard.
- State machine has two states:
  - SYNC (reset state): frame counter held at 0; no strobes. Moves to RUN on the cycle after every enabled source's buffer is full. An all-zero in_slot_enable keeps the block in SYNC.
  - RUN: counter counts 0 to G_FRAME_MCLKS-1, then wraps. The transfer cycle is count == G_FRAME_MCLKS-1.
  - Any RUN cycle with all in_slot_enable low returns to SYNC next cycle. Buffers are kept; out_slots holds its value.
- On the transfer cycle, for each source, using buffer state at the start of the cycle:
  - Enabled and full: slots take the buffer contents; full clears; out_underrun[i] = 0.
  - Enabled and empty: underrun; out_underrun[i] = 1; slot content per Configuration.
  - Disabled: both slots zero; out_underrun[i] = 0.
- Simultaneous accept and transfer on an empty buffer: the new pair goes to the buffer for the next frame; the current frame is an underrun.
- A full buffer blocks the source (ready low) until the next transfer; samples are never overwritten.
- Reset mid-frame: all state cleared next edge; no partial strobe.

## Timing
- Reset values: out_ready = all ones, out_slots = 0, out_frame_strobe = 0, out_underrun = 0, out_running = 0, every buffer empty, counter = 0.
- out_slots, out_frame_strobe and out_underrun are registered and update on the same edge. out_underrun is zero outside strobe cycles.
- out_ready is combinational from registered state and in_slot_enable. There is no path from in_valid to out_ready.
- First strobe comes G_FRAME_MCLKS cycles after out_running rises. After that, strobes are exactly G_FRAME_MCLKS cycles apart.
- Latency: an accepted pair appears on out_slots at the next strobe after acceptance, or the strobe after that if accepted in the transfer cycle.

## Configuration
- TDM_SCHED_MUTE_ON_UNDERRUN_EN
  - Defined: underrun slots output zero.
  - Undefined: underrun slots repeat the last delivered pair for that source, which is zero if none has been delivered since reset.

## Structure
- Shared package tdm_pkg holds:
  - the sched_state_t enum (SYNC, RUN)
  - the slot-index helper constants
  - the counter-width function used for the frame counter
- One natural sub-module: tdm_sample_buffer. It implements the one-entry left/right buffer with full flag, ready logic and last-value hold, and is instantiated G_SOURCES times.

## Test plan
- Reset, then G_SOURCES=4, enable=4'b1111, all sources supply pairs -> out_running rises one cycle after the last buffer fills; strobes exactly 512 cycles apart; slot 2i = left of source i.
- Source 2 stops supplying for one frame -> out_underrun = 4'b0100 on that strobe. Slots 4 and 5 are 0 with the macro defined, and the previous values without it.
- Source 1 offers two pairs within one frame -> second pair held with ready low until the transfer; both pairs delivered on consecutive strobes, none lost.
- in_valid asserted with an empty buffer exactly on the transfer cycle -> current frame flags underrun; that pair appears on the next strobe.
- enable changes 4'b1111 to 4'b0000 mid-RUN -> SYNC next cycle, no further strobes. Re-enabling 4'b0011 -> RUN after sources 0 and 1 fill; slots 4 to 7 zero.
- Assert in_reset at count 300 with full buffers -> all outputs at reset values next cycle; no strobe until a new SYNC completes.
